// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-port cache arbiter.
package cache_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StWait  = 2'd2;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  // Owner encoding doubles as the round-robin "last granted" pointer.
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/cache_arbiter_if.sv
// Requester and cache-side signals of the arbiter; slave is the arbiter's view.
interface cache_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic        i_err;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic        d_err;
  logic [31:0] d_rdata;

  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_type;
  logic        req_do;
  logic [31:0] O_data;
  logic        req_done;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, O_data, req_done,
    output i_gnt, i_rvalid, i_err, i_rdata, d_gnt, d_rvalid, d_err, d_rdata,
    output req_addr, req_data, req_type, req_do
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, O_data, req_done,
    input  i_gnt, i_rvalid, i_err, i_rdata, d_gnt, d_rvalid, d_err, d_rdata,
    input  req_addr, req_data, req_type, req_do
  );

endinterface

// File: rtl/cache_arb_rr.sv
// Two-way round-robin picker; gnt[0] = instruction port, gnt[1] = data port.
module cache_arb_rr (
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = {d_req, i_req};
    // On contention favour whichever port was not granted last.
    if (i_req && d_req) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates instruction and data ports onto a single-outstanding cache request
// channel with a completion timeout.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  cache_arbiter_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            type_q, type_d;
  logic            i_rvalid_q, i_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic            err_q, err_d;
  logic [31:0]     i_rdata_q, i_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic [1:0]      pick;
  logic            done_ok;
  logic            timed_out;

  cache_arb_rr u_rr (
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .last  (owner_q),
    .gnt   (pick)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    type_d    = type_q;
    done_ok   = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick != 2'b00) begin
          state_d = StIssue;
          owner_d = pick[1];
          if (pick[1]) begin
            addr_d = bus.d_addr;
            data_d = bus.d_wdata;
            type_d = bus.d_we;
          end else begin
            addr_d = bus.i_addr;
            data_d = '0;
            type_d = REQ_READ;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (bus.req_done) begin
          state_d = StIdle;
          done_ok = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Completion is registered so the pulse lands in the IDLE cycle after WAIT.
  always_comb begin
    i_rvalid_d = (done_ok || timed_out) && (owner_q == OWNER_INST);
    d_rvalid_d = (done_ok || timed_out) && (owner_q == OWNER_DATA);
    err_d      = timed_out;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (timed_out) begin
      if (owner_q == OWNER_DATA) d_rdata_d = '0;
      else                       i_rdata_d = '0;
    end else if (done_ok && type_q == REQ_READ) begin
      if (owner_q == OWNER_DATA) d_rdata_d = bus.O_data;
      else                       i_rdata_d = bus.O_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      owner_q    <= OWNER_DATA;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      type_q     <= REQ_READ;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      type_q     <= type_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      err_q      <= err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.req_do   = (state_q == StIssue);
  assign bus.i_gnt    = bus.req_do && (owner_q == OWNER_INST);
  assign bus.d_gnt    = bus.req_do && (owner_q == OWNER_DATA);
  assign bus.req_addr = addr_q;
  assign bus.req_data = data_q;
  assign bus.req_type = type_q;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.i_err    = i_rvalid_q && err_q;
  assign bus.d_err    = d_rvalid_q && err_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; inputs driven and outputs sampled on negedge.
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails = 0;

  cache_arbiter_if bus ();

  cache_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ports must never be granted or completed together.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((bus.i_gnt && bus.d_gnt) || (bus.i_rvalid && bus.d_rvalid)) begin
        fails++;
        $display("FAIL exclusive: gnt=%b%b rvalid=%b%b required no overlap",
                 bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid);
      end
    end
  end

  task automatic idle_inputs();
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.O_data   = '0;
    bus.req_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.i_req = 1'b1;
    bus.i_addr = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.req_do, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err,
         bus.req_type} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 00000000", {bus.req_do, bus.i_gnt, bus.d_gnt,
               bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err, bus.req_type});
    end
    checks++;
    if ({bus.req_addr, bus.req_data, bus.i_rdata, bus.d_rdata} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: got %h %h %h %h required all zero",
               bus.req_addr, bus.req_data, bus.i_rdata, bus.d_rdata);
    end
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_single();
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_03FC;
    @(negedge clk);
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.req_do} !== 3'b101) begin
      fails++;
      $display("FAIL rd_issue: i_gnt,d_gnt,req_do=%b required 101",
               {bus.i_gnt, bus.d_gnt, bus.req_do});
    end
    checks++;
    if ({bus.req_addr, bus.req_data, bus.req_type} !== {32'h0000_03FC, 32'h0, REQ_READ}) begin
      fails++;
      $display("FAIL rd_payload: addr=%h data=%h type=%b required 000003fc 00000000 0",
               bus.req_addr, bus.req_data, bus.req_type);
    end
    bus.i_req  = 1'b0;
    bus.i_addr = '0;
    @(negedge clk);
    checks++;
    if ({bus.req_do, bus.i_gnt} !== 2'b00) begin
      fails++;
      $display("FAIL rd_do_pulse: req_do,i_gnt=%b required 00", {bus.req_do, bus.i_gnt});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.i_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rd_early: i_rvalid=%b required 0", bus.i_rvalid);
    end
    bus.req_done = 1'b1;
    bus.O_data   = 32'h1111_0000;
    @(negedge clk);
    bus.req_done = 1'b0;
    bus.O_data   = '0;
    checks++;
    if ({bus.i_rvalid, bus.i_err, bus.d_rvalid} !== 3'b100 || bus.i_rdata !== 32'h1111_0000) begin
      fails++;
      $display("FAIL rd_done: rvalid,err,d_rvalid=%b rdata=%h required 100 11110000",
               {bus.i_rvalid, bus.i_err, bus.d_rvalid}, bus.i_rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h1111_0000) begin
      fails++;
      $display("FAIL rd_after: i_rvalid=%b rdata=%h required 0 11110000",
               bus.i_rvalid, bus.i_rdata);
    end
  endtask

  task automatic test_write();
    logic stable;
    do_reset();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_03FC;
    bus.d_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.req_do, bus.req_type} !== 4'b0111 ||
        bus.req_data !== 32'hAABB_CCDD || bus.req_addr !== 32'h0000_03FC) begin
      fails++;
      $display("FAIL wr_issue: gnt/do/type=%b addr=%h data=%h required 0111 000003fc aabbccdd",
               {bus.i_gnt, bus.d_gnt, bus.req_do, bus.req_type}, bus.req_addr, bus.req_data);
    end
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h5555_5555;
    bus.d_wdata = 32'h0BAD_0BAD;
    stable = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if ({bus.req_addr, bus.req_data, bus.req_type} !== {32'h0000_03FC, 32'hAABB_CCDD, REQ_WRITE})
        stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL wr_stable: stable=%b required 1", stable);
    end
    bus.req_done = 1'b1;
    bus.O_data   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.req_done = 1'b0;
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.i_rvalid} !== 3'b100 || bus.d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL wr_done: rvalid,err,i_rvalid=%b rdata=%h required 100 00000000",
               {bus.d_rvalid, bus.d_err, bus.i_rvalid}, bus.d_rdata);
    end
  endtask

  task automatic test_round_robin();
    int  waited;
    logic got;
    logic exp_inst;
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0100;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      exp_inst = (k % 2 == 0);
      waited = 0;
      got = 1'b0;
      while (!got && waited < 8) begin
        @(negedge clk);
        waited++;
        if (bus.req_do) got = 1'b1;
      end
      checks++;
      if (!got || waited != 1) begin
        fails++;
        $display("FAIL rr_wait[%0d]: got=%b cycles=%0d required 1 1", k, got, waited);
      end
      checks++;
      if ({bus.i_gnt, bus.d_gnt} !== (exp_inst ? 2'b10 : 2'b01) ||
          bus.req_addr !== (exp_inst ? 32'h0000_0100 : 32'h0000_0200)) begin
        fails++;
        $display("FAIL rr_gnt[%0d]: gnt=%b addr=%h required %b %h", k, {bus.i_gnt, bus.d_gnt},
                 bus.req_addr, exp_inst ? 2'b10 : 2'b01, exp_inst ? 32'h100 : 32'h200);
      end
      if (k == 3) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
      @(negedge clk);
      bus.req_done = 1'b1;
      bus.O_data   = 32'h3333_0000 + 32'(k);
      @(negedge clk);
      bus.req_done = 1'b0;
      checks++;
      if ({bus.i_rvalid, bus.d_rvalid} !== (exp_inst ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rr_rvalid[%0d]: rvalid=%b required %b", k, {bus.i_rvalid, bus.d_rvalid},
                 exp_inst ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_timeout();
    int seen;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if ({bus.d_gnt, bus.req_do} !== 2'b11 || bus.d_rdata !== 32'h3333_0003) begin
      fails++;
      $display("FAIL to_issue: d_gnt,req_do=%b d_rdata=%h required 11 33330003",
               {bus.d_gnt, bus.req_do}, bus.d_rdata);
    end
    bus.d_req = 1'b0;
    seen = 0;
    for (int n = 1; n <= int'(TIMEOUT) + 4 && seen == 0; n++) begin
      @(negedge clk);
      if (bus.d_rvalid) seen = n;
    end
    checks++;
    if (seen != int'(TIMEOUT) + 1) begin
      fails++;
      $display("FAIL to_latency: rvalid at %0d cycles after issue required %0d",
               seen, TIMEOUT + 1);
    end
    checks++;
    if ({bus.d_err, bus.i_rvalid} !== 2'b10 || bus.d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL to_err: d_err,i_rvalid=%b d_rdata=%h required 10 00000000",
               {bus.d_err, bus.i_rvalid}, bus.d_rdata);
    end
    @(negedge clk);
    checks++;
    if ({bus.d_rvalid, bus.d_err} !== 2'b00) begin
      fails++;
      $display("FAIL to_pulse: d_rvalid,d_err=%b required 00", {bus.d_rvalid, bus.d_err});
    end
  endtask

  task automatic test_reset_in_wait();
    int extra;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0200;
    @(negedge clk);
    bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_addr !== 32'h0000_0200 || bus.req_do !== 1'b0) begin
      fails++;
      $display("FAIL rw_wait: req_addr=%h req_do=%b required 00000200 0",
               bus.req_addr, bus.req_do);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.req_addr !== 32'h0 ||
        {bus.req_do, bus.i_gnt, bus.d_gnt, bus.d_rvalid, bus.d_err} !== 5'b0) begin
      fails++;
      $display("FAIL rw_async: req_addr=%h ctrl=%b required 00000000 00000", bus.req_addr,
               {bus.req_do, bus.i_gnt, bus.d_gnt, bus.d_rvalid, bus.d_err});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.req_done = 1'b1;
    bus.O_data   = 32'h7777_7777;
    @(negedge clk);
    bus.req_done = 1'b0;
    extra = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.d_rvalid || bus.i_rvalid || bus.req_do) extra++;
    end
    checks++;
    if (extra != 0) begin
      fails++;
      $display("FAIL rw_no_cpl: %0d cycles with activity required 0", extra);
    end
  endtask

  task automatic test_stray_done();
    do_reset();
    bus.req_done = 1'b1;
    bus.O_data   = 32'h9999_9999;
    @(negedge clk);
    bus.req_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.req_do} !== 3'b000 || bus.i_rdata !== 32'h0) begin
      fails++;
      $display("FAIL sd_idle: rvalid/do=%b i_rdata=%h required 000 00000000",
               {bus.i_rvalid, bus.d_rvalid, bus.req_do}, bus.i_rdata);
    end
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_03FC;
    @(negedge clk);
    checks++;
    if ({bus.i_gnt, bus.req_do} !== 2'b11) begin
      fails++;
      $display("FAIL sd_issue: i_gnt,req_do=%b required 11", {bus.i_gnt, bus.req_do});
    end
    bus.i_req    = 1'b0;
    bus.i_addr   = 32'h2222_2222;
    bus.req_done = 1'b1;
    @(negedge clk);
    bus.req_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_addr !== 32'h0000_03FC || bus.i_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL sd_hold: req_addr=%h i_rvalid=%b required 000003fc 0",
               bus.req_addr, bus.i_rvalid);
    end
    bus.req_done = 1'b1;
    bus.O_data   = 32'h1234_5678;
    @(negedge clk);
    bus.req_done = 1'b0;
    checks++;
    if ({bus.i_rvalid, bus.i_err} !== 2'b10 || bus.i_rdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL sd_done: i_rvalid,i_err=%b rdata=%h required 10 12345678",
               {bus.i_rvalid, bus.i_err}, bus.i_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_read_single();
    test_write();
    test_round_robin();
    test_timeout();
    test_reset_in_wait();
    test_stray_done();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of cycles spent waiting for req_done before an error completion.
REQ-002 Port clk, input, 1, is the single clock; all state is updated on its rising edge.
REQ-003 Port reset, input, 1, is the asynchronous, active-low reset.
REQ-004 Ports i_req, i_addr[31:0], input, are the instruction port (read-only): request level and word address.
REQ-005 Ports i_gnt, i_rvalid, i_err, output, 1 each, plus i_rdata[31:0], output, are the instruction-port grant pulse, completion pulse, error flag and read data.
REQ-006 Ports d_req, d_we, d_addr[31:0], d_wdata[31:0], input, are the data port: request level, 1=write, address and write data.
REQ-007 Ports d_gnt, d_rvalid, d_err, output, 1 each, plus d_rdata[31:0], output, are the data-port equivalents of REQ-005.
REQ-008 Ports req_addr[31:0], req_data[31:0], req_type (0=read, 1=write) and req_do, output, drive the cache request.
REQ-009 Ports O_data[31:0] and req_done, input, are the cache read data and completion strobe.

Function
REQ-010 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-011 IDLE: if i_req or d_req is high at a clock edge, latch the winner's addr/wdata/type into req_* and go to ISSUE; otherwise stay.
REQ-012 Arbitration: a single requester wins; when both request, grant the port not granted last (round-robin); after reset the instruction port has priority.
REQ-013 Instruction-port requests SHALL always drive req_type=0 and req_data=0.
REQ-014 ISSUE lasts exactly one cycle: req_do=1 and the winner's x_gnt=1 in that cycle; next state WAIT.
REQ-015 Requesters hold x_req and their payload until x_gnt; changes to the payload after x_gnt SHALL NOT affect the issued request.
REQ-016 req_addr, req_data and req_type SHALL stay stable from ISSUE until the WAIT→IDLE transition.
REQ-017 WAIT: on req_done=1, return to IDLE and, in the next cycle, pulse the owner's x_rvalid for one cycle with x_err=0.
REQ-018 For reads, x_rdata SHALL take the O_data value sampled on the req_done cycle; write completions leave x_rdata unchanged.
REQ-019 WAIT counter: it starts at 0 on entering WAIT; if it reaches TIMEOUT-1 without req_done, go to IDLE and pulse x_rvalid with x_err=1 and x_rdata=0.
REQ-020 req_done SHALL be ignored in IDLE and ISSUE.
REQ-021 At most one request is outstanding, so request-to-completion latency is 2 + (cycles until req_done) + 1.
REQ-022 x_gnt and x_rvalid SHALL never be high for both ports in the same cycle.
REQ-023 A new grant MAY be issued in the IDLE cycle that coincides with the previous x_rvalid pulse; this gives back-to-back throughput.

Reset
REQ-024 reset=0 SHALL immediately force IDLE and clear req_do, all gnt/rvalid/err outputs, req_* and x_rdata to 0, the counter to 0 and the round-robin pointer to "data last".
REQ-025 Reset during WAIT abandons the request and produces no completion pulse.

Structure
REQ-026 Package cache_arb_pkg SHALL hold the state enum, REQ_READ=0/REQ_WRITE=1 and TIMEOUT_DEFAULT=64.
REQ-027 The two-way round-robin picker SHALL be the sub-module cache_arb_rr (inputs i_req, d_req, pointer; output one-hot grant).

Verification
REQ-028 Scenario 1: i_req read 0x0000_03FC, cache req_done after 5 cycles with O_data=0x1111_0000 → i_gnt in ISSUE, req_do one cycle, i_rvalid with i_rdata=0x1111_0000, i_err=0.
REQ-029 Scenario 2: d_req write 0x0000_03FC with d_wdata 0xAABB_CCDD → req_type=1 and req_data=0xAABB_CCDD stable until req_done; d_rvalid=1 and d_rdata unchanged.
REQ-030 Scenario 3: i_req and d_req asserted together and held → grants alternate I, D, I, D, and no cycle has both gnt signals high.
REQ-031 Scenario 4: d_req read 0x0000_0200 with req_done withheld → d_rvalid with d_err=1 and d_rdata=0 exactly TIMEOUT cycles after entering WAIT.
REQ-032 Scenario 5: reset asserted in WAIT for 0x0000_0200 → outputs 0 asynchronously, and no d_rvalid occurs after release.
REQ-033 Scenario 6: req_done pulsed while IDLE, and payload changed after gnt to 0x2222_2222 → the stray req_done is ignored and req_addr keeps its originally latched value.
